// File: rtl/n1_sagu_seq_if.sv
// Signal bundle between the flow controller, the SAGU sequencer and the DSP pointer datapath.
// Probe outputs are present only when N1_SAGU_SEQ_HWM_EN is defined.
interface n1_sagu_seq_if #(
    parameter int SP_WIDTH = 12
);
    // Handshake: the requester raises fc2sagu_req_i with the command fields stable and
    // holds them until sagu2fc_ack_o pulses for exactly one cycle; the command completes
    // on that cycle, and req still high in the following cycle starts a new command.
    logic                fc2sagu_req_i;
    logic                sagu2fc_ack_o;
    logic [1:0]          fc2sagu_ps_op_i;
    logic [SP_WIDTH-1:0] fc2sagu_ps_offs_i;
    logic [SP_WIDTH-1:0] fc2sagu_ps_val_i;
    logic [1:0]          fc2sagu_rs_op_i;
    logic [SP_WIDTH-1:0] fc2sagu_rs_offs_i;
    logic [SP_WIDTH-1:0] fc2sagu_rs_val_i;
    logic                fc2sagu_err_clr_i;
    logic                sagu2fc_ps_of_o;
    logic                sagu2fc_ps_uf_o;
    logic                sagu2fc_rs_of_o;
    logic                sagu2fc_rs_uf_o;

    logic                sagu2dsp_psp_hold_o;
    logic                sagu2dsp_rsp_hold_o;
    logic                sagu2dsp_psp_op_sel_o;
    logic                sagu2dsp_rsp_op_sel_o;
    logic [SP_WIDTH-1:0] sagu2dsp_psp_offs_o;
    logic [SP_WIDTH-1:0] sagu2dsp_rsp_offs_o;
    logic [SP_WIDTH-1:0] sagu2dsp_psp_load_val_o;
    logic [SP_WIDTH-1:0] sagu2dsp_rsp_load_val_o;
    logic [SP_WIDTH-1:0] dsp2sagu_psp_next_i;
    logic [SP_WIDTH-1:0] dsp2sagu_rsp_next_i;
`ifdef N1_SAGU_SEQ_HWM_EN
    logic [SP_WIDTH-1:0] prb_sagu_ps_hwm_o;
    logic [SP_WIDTH-1:0] prb_sagu_rs_hwm_o;
`endif

    modport master (
        input  fc2sagu_req_i, fc2sagu_ps_op_i, fc2sagu_ps_offs_i, fc2sagu_ps_val_i,
        input  fc2sagu_rs_op_i, fc2sagu_rs_offs_i, fc2sagu_rs_val_i, fc2sagu_err_clr_i,
        input  dsp2sagu_psp_next_i, dsp2sagu_rsp_next_i,
        output sagu2fc_ack_o, sagu2fc_ps_of_o, sagu2fc_ps_uf_o, sagu2fc_rs_of_o, sagu2fc_rs_uf_o,
        output sagu2dsp_psp_hold_o, sagu2dsp_rsp_hold_o,
        output sagu2dsp_psp_op_sel_o, sagu2dsp_rsp_op_sel_o,
        output sagu2dsp_psp_offs_o, sagu2dsp_rsp_offs_o,
        output sagu2dsp_psp_load_val_o, sagu2dsp_rsp_load_val_o
`ifdef N1_SAGU_SEQ_HWM_EN
        ,
        output prb_sagu_ps_hwm_o, prb_sagu_rs_hwm_o
`endif
    );

    modport slave (
        output fc2sagu_req_i, fc2sagu_ps_op_i, fc2sagu_ps_offs_i, fc2sagu_ps_val_i,
        output fc2sagu_rs_op_i, fc2sagu_rs_offs_i, fc2sagu_rs_val_i, fc2sagu_err_clr_i,
        output dsp2sagu_psp_next_i, dsp2sagu_rsp_next_i,
        input  sagu2fc_ack_o, sagu2fc_ps_of_o, sagu2fc_ps_uf_o, sagu2fc_rs_of_o, sagu2fc_rs_uf_o,
        input  sagu2dsp_psp_hold_o, sagu2dsp_rsp_hold_o,
        input  sagu2dsp_psp_op_sel_o, sagu2dsp_rsp_op_sel_o,
        input  sagu2dsp_psp_offs_o, sagu2dsp_rsp_offs_o,
        input  sagu2dsp_psp_load_val_o, sagu2dsp_rsp_load_val_o
`ifdef N1_SAGU_SEQ_HWM_EN
        ,
        input  prb_sagu_ps_hwm_o, prb_sagu_rs_hwm_o
`endif
    );
endinterface

// File: rtl/n1_sagu_seq.sv
// Stack address sequencer: bounds-checks PSP/RSP commands and issues one-cycle DSP updates.
// Optional high-water-mark probes are built when N1_SAGU_SEQ_HWM_EN is defined.
module n1_sagu_seq #(
    parameter int                  SP_WIDTH = 12,
    parameter logic [SP_WIDTH-1:0] PS_BASE  = 12'h000,
    parameter logic [SP_WIDTH-1:0] PS_LIMIT = 12'h7FF,
    parameter logic [SP_WIDTH-1:0] RS_BASE  = 12'h800,
    parameter logic [SP_WIDTH-1:0] RS_LIMIT = 12'hFFF
) (
    input  logic          clk_i,
    input  logic          sync_rst_i,
    n1_sagu_seq_if.master bus,
    output logic [1:0]    dbg_state_o
);

    // Two guard bits keep next+offs exact over the full operand range (no wrap into the sign).
    localparam int CW = SP_WIDTH + 2;

    localparam logic [1:0] OP_ADD  = 2'b01;
    localparam logic [1:0] OP_LOAD = 2'b10;
    localparam logic [1:0] OP_RST  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CHECK = 2'd1,
        ST_ISSUE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_next_state;

    logic [1:0]          r_ps_op;
    logic [SP_WIDTH-1:0] r_ps_offs;
    logic [SP_WIDTH-1:0] r_ps_val;
    logic [1:0]          r_rs_op;
    logic [SP_WIDTH-1:0] r_rs_offs;
    logic [SP_WIDTH-1:0] r_rs_val;

    logic                r_ps_upd;
    logic                r_ps_of_det;
    logic                r_ps_uf_det;
    logic [SP_WIDTH-1:0] r_ps_new;
    logic                r_rs_upd;
    logic                r_rs_of_det;
    logic                r_rs_uf_det;
    logic [SP_WIDTH-1:0] r_rs_new;

    logic r_ps_of;
    logic r_ps_uf;
    logic r_rs_of;
    logic r_rs_uf;

    logic signed [CW-1:0] w_ps_cand;
    logic signed [CW-1:0] w_rs_cand;
    logic                 w_ps_of;
    logic                 w_ps_uf;
    logic                 w_rs_of;
    logic                 w_rs_uf;
    logic                 w_issue;

    function automatic logic signed [CW-1:0] f_cand(
        input logic [1:0]          op,
        input logic [SP_WIDTH-1:0] cur,
        input logic [SP_WIDTH-1:0] offs,
        input logic [SP_WIDTH-1:0] val,
        input logic [SP_WIDTH-1:0] base
    );
        logic signed [CW-1:0] v;
        case (op)
            OP_ADD:  v = $signed({2'b00, cur}) + $signed({{2{offs[SP_WIDTH-1]}}, offs});
            OP_LOAD: v = $signed({2'b00, val});
            OP_RST:  v = $signed({2'b00, base});
            default: v = $signed({2'b00, cur});
        endcase
        return v;
    endfunction

    assign w_ps_cand = f_cand(r_ps_op, bus.dsp2sagu_psp_next_i, r_ps_offs, r_ps_val, PS_BASE);
    assign w_rs_cand = f_cand(r_rs_op, bus.dsp2sagu_rsp_next_i, r_rs_offs, r_rs_val, RS_BASE);

    assign w_ps_uf = (w_ps_cand < $signed({2'b00, PS_BASE}));
    assign w_ps_of = (w_ps_cand > $signed({2'b00, PS_LIMIT}));
    assign w_rs_uf = (w_rs_cand < $signed({2'b00, RS_BASE}));
    assign w_rs_of = (w_rs_cand > $signed({2'b00, RS_LIMIT}));

    assign w_issue     = (r_state == ST_ISSUE);
    assign dbg_state_o = r_state;

    always_ff @(posedge clk_i) begin
        if (!sync_rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:  if (bus.fc2sagu_req_i) w_next_state = ST_CHECK;
            ST_CHECK: w_next_state = ST_ISSUE;
            ST_ISSUE: w_next_state = ST_IDLE;
            default:  w_next_state = ST_IDLE;
        endcase
    end

    // Command capture in IDLE, legality decision latched at the end of CHECK.
    always_ff @(posedge clk_i) begin
        if (!sync_rst_i) begin
            r_ps_op     <= '0;
            r_ps_offs   <= '0;
            r_ps_val    <= '0;
            r_rs_op     <= '0;
            r_rs_offs   <= '0;
            r_rs_val    <= '0;
            r_ps_upd    <= 1'b0;
            r_ps_of_det <= 1'b0;
            r_ps_uf_det <= 1'b0;
            r_ps_new    <= '0;
            r_rs_upd    <= 1'b0;
            r_rs_of_det <= 1'b0;
            r_rs_uf_det <= 1'b0;
            r_rs_new    <= '0;
        end else begin
            if (r_state == ST_IDLE && bus.fc2sagu_req_i) begin
                r_ps_op   <= bus.fc2sagu_ps_op_i;
                r_ps_offs <= bus.fc2sagu_ps_offs_i;
                r_ps_val  <= bus.fc2sagu_ps_val_i;
                r_rs_op   <= bus.fc2sagu_rs_op_i;
                r_rs_offs <= bus.fc2sagu_rs_offs_i;
                r_rs_val  <= bus.fc2sagu_rs_val_i;
            end
            if (r_state == ST_CHECK) begin
                r_ps_upd    <= !w_ps_of && !w_ps_uf && (r_ps_op != 2'b00);
                r_ps_of_det <= w_ps_of;
                r_ps_uf_det <= w_ps_uf;
                r_ps_new    <= w_ps_cand[SP_WIDTH-1:0];
                r_rs_upd    <= !w_rs_of && !w_rs_uf && (r_rs_op != 2'b00);
                r_rs_of_det <= w_rs_of;
                r_rs_uf_det <= w_rs_uf;
                r_rs_new    <= w_rs_cand[SP_WIDTH-1:0];
            end
        end
    end

    always_comb begin
        bus.sagu2fc_ack_o           = w_issue;
        bus.sagu2dsp_psp_hold_o     = 1'b1;
        bus.sagu2dsp_psp_op_sel_o   = 1'b0;
        bus.sagu2dsp_psp_offs_o     = '0;
        bus.sagu2dsp_psp_load_val_o = '0;
        bus.sagu2dsp_rsp_hold_o     = 1'b1;
        bus.sagu2dsp_rsp_op_sel_o   = 1'b0;
        bus.sagu2dsp_rsp_offs_o     = '0;
        bus.sagu2dsp_rsp_load_val_o = '0;
        if (w_issue && r_ps_upd) begin
            bus.sagu2dsp_psp_hold_o = 1'b0;
            if (r_ps_op == OP_ADD) begin
                bus.sagu2dsp_psp_offs_o = r_ps_offs;
            end else begin
                bus.sagu2dsp_psp_op_sel_o   = 1'b1;
                bus.sagu2dsp_psp_load_val_o = r_ps_new;
            end
        end
        if (w_issue && r_rs_upd) begin
            bus.sagu2dsp_rsp_hold_o = 1'b0;
            if (r_rs_op == OP_ADD) begin
                bus.sagu2dsp_rsp_offs_o = r_rs_offs;
            end else begin
                bus.sagu2dsp_rsp_op_sel_o   = 1'b1;
                bus.sagu2dsp_rsp_load_val_o = r_rs_new;
            end
        end
    end

    // Sticky flags: a set in the ISSUE cycle overrides a simultaneous clear.
    always_ff @(posedge clk_i) begin
        if (!sync_rst_i) begin
            r_ps_of <= 1'b0;
            r_ps_uf <= 1'b0;
            r_rs_of <= 1'b0;
            r_rs_uf <= 1'b0;
        end else begin
            r_ps_of <= (r_ps_of && !bus.fc2sagu_err_clr_i) || (w_issue && r_ps_of_det);
            r_ps_uf <= (r_ps_uf && !bus.fc2sagu_err_clr_i) || (w_issue && r_ps_uf_det);
            r_rs_of <= (r_rs_of && !bus.fc2sagu_err_clr_i) || (w_issue && r_rs_of_det);
            r_rs_uf <= (r_rs_uf && !bus.fc2sagu_err_clr_i) || (w_issue && r_rs_uf_det);
        end
    end

    assign bus.sagu2fc_ps_of_o = r_ps_of;
    assign bus.sagu2fc_ps_uf_o = r_ps_uf;
    assign bus.sagu2fc_rs_of_o = r_rs_of;
    assign bus.sagu2fc_rs_uf_o = r_rs_uf;

`ifdef N1_SAGU_SEQ_HWM_EN
    logic [SP_WIDTH-1:0] r_ps_hwm;
    logic [SP_WIDTH-1:0] r_rs_hwm;

    always_ff @(posedge clk_i) begin
        if (!sync_rst_i) begin
            r_ps_hwm <= PS_BASE;
            r_rs_hwm <= RS_BASE;
        end else begin
            if (w_issue && r_ps_upd && (r_ps_new > r_ps_hwm)) r_ps_hwm <= r_ps_new;
            if (w_issue && r_rs_upd && (r_rs_new > r_rs_hwm)) r_rs_hwm <= r_rs_new;
        end
    end

    assign bus.prb_sagu_ps_hwm_o = r_ps_hwm;
    assign bus.prb_sagu_rs_hwm_o = r_rs_hwm;
`endif

endmodule

// File: tb/tb_n1_sagu_seq.sv
// Directed bench for n1_sagu_seq with a behavioural DSP pointer model and an ack-driven scoreboard.
module tb_n1_sagu_seq;
  localparam int W = 12;

  logic clk = 1'b0;
  logic rst_n;
  logic [1:0] dbg_state;
  always #5 clk = ~clk;

  n1_sagu_seq_if #(.SP_WIDTH(W)) bus();

  n1_sagu_seq #(.SP_WIDTH(W)) dut (
    .clk_i      (clk),
    .sync_rst_i (rst_n),
    .bus        (bus),
    .dbg_state_o(dbg_state)
  );

  // DSP pointer datapath model
  logic [W-1:0] psp = 12'h000;
  logic [W-1:0] rsp = 12'h800;
  always @(posedge clk) begin
    if (!bus.sagu2dsp_psp_hold_o)
      psp <= bus.sagu2dsp_psp_op_sel_o ? bus.sagu2dsp_psp_load_val_o : psp + bus.sagu2dsp_psp_offs_o;
    if (!bus.sagu2dsp_rsp_hold_o)
      rsp <= bus.sagu2dsp_rsp_op_sel_o ? bus.sagu2dsp_rsp_load_val_o : rsp + bus.sagu2dsp_rsp_offs_o;
  end
  assign bus.dsp2sagu_psp_next_i = psp;
  assign bus.dsp2sagu_rsp_next_i = rsp;

  int n_checks = 0;
  int n_fail = 0;
  logic [51:0] exp_q[$];

  localparam logic [25:0] SIDE_IDLE = {1'b1, 1'b0, 12'h000, 12'h000};

  function automatic logic [25:0] side(input logic h, input logic sel, input logic [W-1:0] offs,
                                       input logic [W-1:0] lv);
    return {h, sel, offs, lv};
  endfunction

  function automatic logic [51:0] ctrl_vec();
    return {bus.sagu2dsp_psp_hold_o, bus.sagu2dsp_psp_op_sel_o, bus.sagu2dsp_psp_offs_o,
            bus.sagu2dsp_psp_load_val_o, bus.sagu2dsp_rsp_hold_o, bus.sagu2dsp_rsp_op_sel_o,
            bus.sagu2dsp_rsp_offs_o, bus.sagu2dsp_rsp_load_val_o};
  endfunction

  function automatic logic [3:0] flags();
    return {bus.sagu2fc_ps_of_o, bus.sagu2fc_ps_uf_o, bus.sagu2fc_rs_of_o, bus.sagu2fc_rs_uf_o};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every ack pops one expectation and compares the DSP controls of that cycle.
  always @(negedge clk) begin
    if (bus.sagu2fc_ack_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_ack: ack=1 with no outstanding command");
      end else begin
        chk("dsp_ctrl", {12'h000, ctrl_vec()}, {12'h000, exp_q.pop_front()});
      end
    end
  end

  task automatic do_cmd(input string name, input logic [1:0] pso, input logic [W-1:0] pof,
                        input logic [W-1:0] psv, input logic [1:0] rso, input logic [W-1:0] rof,
                        input logic [W-1:0] rsv, input logic [51:0] exp);
    int lat;
    lat = 0;
    exp_q.push_back(exp);
    @(negedge clk);
    bus.fc2sagu_ps_op_i   = pso;
    bus.fc2sagu_ps_offs_i = pof;
    bus.fc2sagu_ps_val_i  = psv;
    bus.fc2sagu_rs_op_i   = rso;
    bus.fc2sagu_rs_offs_i = rof;
    bus.fc2sagu_rs_val_i  = rsv;
    bus.fc2sagu_req_i     = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (bus.sagu2fc_ack_o === 1'b1) begin
        lat = c;
        break;
      end
    end
    bus.fc2sagu_req_i = 1'b0;
    if (lat == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_ack_timeout: no ack within 8 cycles, expected 2", name);
      exp_q.delete();
    end else begin
      chk({name, "_latency"}, 64'(lat), 64'd2);
    end
    @(negedge clk);
    chk({name, "_idle_ctrl"}, {12'h000, ctrl_vec()}, {12'h000, SIDE_IDLE, SIDE_IDLE});
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    bus.fc2sagu_err_clr_i = 1'b1;
    @(negedge clk);
    bus.fc2sagu_err_clr_i = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    bus.fc2sagu_req_i     = 1'b0;
    bus.fc2sagu_err_clr_i = 1'b0;
    bus.fc2sagu_ps_op_i   = 2'b00;
    bus.fc2sagu_ps_offs_i = '0;
    bus.fc2sagu_ps_val_i  = '0;
    bus.fc2sagu_rs_op_i   = 2'b00;
    bus.fc2sagu_rs_offs_i = '0;
    bus.fc2sagu_rs_val_i  = '0;
    repeat (3) @(negedge clk);
    chk("reset_ctrl", {12'h000, ctrl_vec()}, {12'h000, SIDE_IDLE, SIDE_IDLE});
    chk("reset_ack", 64'(bus.sagu2fc_ack_o), 64'd0);
    chk("reset_flags", 64'(flags()), 64'd0);
    chk("reset_state", 64'(dbg_state), 64'd0);
`ifdef N1_SAGU_SEQ_HWM_EN
    chk("reset_ps_hwm", 64'(bus.prb_sagu_ps_hwm_o), 64'h000);
    chk("reset_rs_hwm", 64'(bus.prb_sagu_rs_hwm_o), 64'h800);
`endif
    rst_n = 1'b1;

    do_cmd("ps_load_010", 2'b10, 12'h000, 12'h010, 2'b00, 12'h000, 12'h000,
           {side(1'b0, 1'b1, 12'h000, 12'h010), SIDE_IDLE});
    chk("psp_010", 64'(psp), 64'h010);

    do_cmd("ps_add_5", 2'b01, 12'h005, 12'h000, 2'b00, 12'h000, 12'h000,
           {side(1'b0, 1'b0, 12'h005, 12'h000), SIDE_IDLE});
    chk("psp_015", 64'(psp), 64'h015);
    chk("flags_after_add", 64'(flags()), 64'h0);

    do_cmd("ps_load_7fe", 2'b10, 12'h000, 12'h7FE, 2'b00, 12'h000, 12'h000,
           {side(1'b0, 1'b1, 12'h000, 12'h7FE), SIDE_IDLE});
    do_cmd("ps_add_of", 2'b01, 12'h003, 12'h000, 2'b00, 12'h000, 12'h000, {SIDE_IDLE, SIDE_IDLE});
    chk("psp_7fe_kept", 64'(psp), 64'h7FE);
    chk("flags_ps_of", 64'(flags()), 64'b1000);
    pulse_clr();
    @(negedge clk);
    chk("flags_clr_ps", 64'(flags()), 64'h0);

    do_cmd("rs_add_2", 2'b00, 12'h000, 12'h000, 2'b01, 12'h002, 12'h000,
           {SIDE_IDLE, side(1'b0, 1'b0, 12'h002, 12'h000)});
    chk("rsp_802", 64'(rsp), 64'h802);
    do_cmd("rs_add_uf", 2'b00, 12'h000, 12'h000, 2'b01, 12'hFFC, 12'h000, {SIDE_IDLE, SIDE_IDLE});
    chk("rsp_802_kept", 64'(rsp), 64'h802);
    chk("flags_rs_uf", 64'(flags()), 64'b0001);
    pulse_clr();
    @(negedge clk);
    chk("flags_clr_rs", 64'(flags()), 64'h0);

    do_cmd("ps_load_rs_rst", 2'b10, 12'h000, 12'h100, 2'b11, 12'h000, 12'h000,
           {side(1'b0, 1'b1, 12'h000, 12'h100), side(1'b0, 1'b1, 12'h000, 12'h800)});
    chk("psp_100", 64'(psp), 64'h100);
    chk("rsp_800", 64'(rsp), 64'h800);

    do_cmd("both_nop", 2'b00, 12'h123, 12'h456, 2'b00, 12'h789, 12'hABC, {SIDE_IDLE, SIDE_IDLE});
    chk("psp_nop", 64'(psp), 64'h100);
    chk("flags_nop", 64'(flags()), 64'h0);

    // Negative candidate with a clear held across the ISSUE edge: the set must win.
    bus.fc2sagu_err_clr_i = 1'b1;
    do_cmd("ps_add_neg", 2'b01, 12'h800, 12'h000, 2'b00, 12'h000, 12'h000, {SIDE_IDLE, SIDE_IDLE});
    chk("flags_set_wins", 64'(flags()), 64'b0100);
    bus.fc2sagu_err_clr_i = 1'b0;
    chk("psp_neg_kept", 64'(psp), 64'h100);
    pulse_clr();
    @(negedge clk);
    chk("flags_clr_uf", 64'(flags()), 64'h0);

    do_cmd("rs_load_fff", 2'b00, 12'h000, 12'h000, 2'b10, 12'h000, 12'hFFF,
           {SIDE_IDLE, side(1'b0, 1'b1, 12'h000, 12'hFFF)});
    chk("rsp_fff", 64'(rsp), 64'hFFF);
    do_cmd("rs_add_nowrap", 2'b00, 12'h000, 12'h000, 2'b01, 12'h7FF, 12'h000, {SIDE_IDLE, SIDE_IDLE});
    chk("rsp_fff_kept", 64'(rsp), 64'hFFF);
    chk("flags_rs_of", 64'(flags()), 64'b0010);
    do_cmd("ps_load_lim", 2'b10, 12'h000, 12'h7FF, 2'b10, 12'h000, 12'h7FF,
           {side(1'b0, 1'b1, 12'h000, 12'h7FF), SIDE_IDLE});
    chk("psp_7ff", 64'(psp), 64'h7FF);
    chk("flags_rs_load_uf", 64'(flags()), 64'b0011);
    do_cmd("ps_load_800", 2'b10, 12'h000, 12'h800, 2'b00, 12'h000, 12'h000, {SIDE_IDLE, SIDE_IDLE});
    chk("psp_7ff_kept", 64'(psp), 64'h7FF);
    chk("flags_multi", 64'(flags()), 64'b1011);

    // Reset while the command sits in CHECK: dropped, no ack, flags cleared.
    @(negedge clk);
    bus.fc2sagu_ps_op_i  = 2'b10;
    bus.fc2sagu_ps_val_i = 12'h123;
    bus.fc2sagu_rs_op_i  = 2'b00;
    bus.fc2sagu_req_i    = 1'b1;
    @(negedge clk);
    chk("pre_rst_state", 64'(dbg_state), 64'd1);
    rst_n = 1'b0;
    bus.fc2sagu_req_i = 1'b0;
    @(negedge clk);
    chk("rst_chk_ctrl", {12'h000, ctrl_vec()}, {12'h000, SIDE_IDLE, SIDE_IDLE});
    chk("rst_chk_flags", 64'(flags()), 64'h0);
    chk("rst_chk_state", 64'(dbg_state), 64'd0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("psp_after_rst", 64'(psp), 64'h7FF);

    do_cmd("post_rst_load", 2'b10, 12'h000, 12'h020, 2'b00, 12'h000, 12'h000,
           {side(1'b0, 1'b1, 12'h000, 12'h020), SIDE_IDLE});
    chk("psp_020", 64'(psp), 64'h020);

    do_cmd("ps_load_300", 2'b10, 12'h000, 12'h300, 2'b00, 12'h000, 12'h000,
           {side(1'b0, 1'b1, 12'h000, 12'h300), SIDE_IDLE});
    do_cmd("ps_load_100b", 2'b10, 12'h000, 12'h100, 2'b00, 12'h000, 12'h000,
           {side(1'b0, 1'b1, 12'h000, 12'h100), SIDE_IDLE});
`ifdef N1_SAGU_SEQ_HWM_EN
    chk("ps_hwm_300", 64'(bus.prb_sagu_ps_hwm_o), 64'h300);
`endif
    do_cmd("ps_load_900", 2'b10, 12'h000, 12'h900, 2'b00, 12'h000, 12'h000, {SIDE_IDLE, SIDE_IDLE});
    chk("psp_100_final", 64'(psp), 64'h100);
    chk("flags_final", 64'(flags()), 64'b1000);
`ifdef N1_SAGU_SEQ_HWM_EN
    chk("ps_hwm_kept", 64'(bus.prb_sagu_ps_hwm_o), 64'h300);
    chk("rs_hwm_base", 64'(bus.prb_sagu_rs_hwm_o), 64'h800);
`endif

    repeat (3) @(negedge clk);
    chk("exp_q_drained", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
